// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: registered instruction decoder with a valid/ready
// handshake toward fetch and execute, plus a flush input.
module riscv_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic [31:0] in_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [4:0]  alu_op_o,
    output logic [1:0]  a_sel_o,
    output logic        b_sel_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        reg_we_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic        valid_q;
    logic [31:0] pc_q, imm_q, imm_d;
    logic [4:0]  alu_q, alu_d, rs1_q, rs2_q, rd_q;
    logic [1:0]  a_sel_q, a_sel_d;
    logic [2:0]  size_q, size_d;
    logic        b_sel_q, b_sel_d, we_q, we_d, req_q, req_d;
    logic        mwe_q, mwe_d, br_q, br_d, jal_q, jal_d;
    logic        jalr_q, jalr_d, ill_q, ill_d;
    logic        xfer;

    assign opcode = in_instr_i[6:0];
    assign f3     = in_instr_i[14:12];
    assign f7     = in_instr_i[31:25];

    assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_s = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
    assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                    in_instr_i[30:25], in_instr_i[11:8], 1'b0};
    assign imm_u = {in_instr_i[31:12], 12'b0};
    assign imm_j = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                    in_instr_i[20], in_instr_i[30:21], 1'b0};

    always_comb begin
        alu_d   = 5'b0;
        a_sel_d = 2'd0;
        b_sel_d = 1'b0;
        imm_d   = 32'b0;
        we_d    = 1'b0;
        req_d   = 1'b0;
        mwe_d   = 1'b0;
        size_d  = 3'b0;
        br_d    = 1'b0;
        jal_d   = 1'b0;
        jalr_d  = 1'b0;
        ill_d   = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                alu_d = {f7[5], f3};
                we_d  = 1'b1;
                ill_d = !((f7 == 7'h00) ||
                          (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                // funct7[5] only selects SRA for right shifts
                alu_d   = {(f3 == 3'b101) & f7[5], f3};
                b_sel_d = 1'b1;
                imm_d   = imm_i;
                we_d    = 1'b1;
                if (f3 == 3'b001) ill_d = (f7 != 7'h00);
                if (f3 == 3'b101) ill_d = !(f7 == 7'h00 || f7 == 7'h20);
            end
            OPC_LUI: begin
                a_sel_d = 2'd2;
                b_sel_d = 1'b1;
                imm_d   = imm_u;
                we_d    = 1'b1;
            end
            OPC_AUIPC: begin
                a_sel_d = 2'd1;
                b_sel_d = 1'b1;
                imm_d   = imm_u;
                we_d    = 1'b1;
            end
            OPC_JAL: begin
                jal_d = 1'b1;
                imm_d = imm_j;
                we_d  = 1'b1;
            end
            OPC_JALR: begin
                jalr_d  = 1'b1;
                b_sel_d = 1'b1;
                imm_d   = imm_i;
                we_d    = 1'b1;
                ill_d   = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                br_d  = 1'b1;
                alu_d = {2'b11, f3};
                imm_d = imm_b;
                ill_d = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                req_d   = 1'b1;
                b_sel_d = 1'b1;
                imm_d   = imm_i;
                we_d    = 1'b1;
                size_d  = f3;
                ill_d   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                req_d   = 1'b1;
                mwe_d   = 1'b1;
                b_sel_d = 1'b1;
                imm_d   = imm_s;
                size_d  = f3;
                ill_d   = (f3 > 3'b010);
            end
            OPC_MISC: ;
            default: ill_d = 1'b1;
        endcase
        // an illegal bundle must never have side effects downstream
        if (ill_d) begin
            alu_d   = 5'b0;
            a_sel_d = 2'd0;
            b_sel_d = 1'b0;
            imm_d   = 32'b0;
            we_d    = 1'b0;
            req_d   = 1'b0;
            mwe_d   = 1'b0;
            size_d  = 3'b0;
            br_d    = 1'b0;
            jal_d   = 1'b0;
            jalr_d  = 1'b0;
        end
    end

    assign in_ready_o = !valid_q || out_ready_i;
    assign xfer       = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            alu_q   <= 5'b0;
            a_sel_q <= 2'd0;
            b_sel_q <= 1'b0;
            imm_q   <= 32'b0;
            rs1_q   <= 5'b0;
            rs2_q   <= 5'b0;
            rd_q    <= 5'b0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            mwe_q   <= 1'b0;
            size_q  <= 3'b0;
            br_q    <= 1'b0;
            jal_q   <= 1'b0;
            jalr_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc_i;
            alu_q   <= alu_d;
            a_sel_q <= a_sel_d;
            b_sel_q <= b_sel_d;
            imm_q   <= imm_d;
            rs1_q   <= in_instr_i[19:15];
            rs2_q   <= in_instr_i[24:20];
            rd_q    <= in_instr_i[11:7];
            we_q    <= we_d;
            req_q   <= req_d;
            mwe_q   <= mwe_d;
            size_q  <= size_d;
            br_q    <= br_d;
            jal_q   <= jal_d;
            jalr_q  <= jalr_d;
            ill_q   <= ill_d;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_pc_o    = pc_q;
    assign alu_op_o    = alu_q;
    assign a_sel_o     = a_sel_q;
    assign b_sel_o     = b_sel_q;
    assign imm_o       = imm_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign rd_o        = rd_q;
    assign reg_we_o    = we_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = mwe_q;
    assign mem_size_o  = size_q;
    assign branch_o    = br_q;
    assign jal_o       = jal_q;
    assign jalr_o      = jalr_q;
    assign illegal_o   = ill_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: hand-computed decode vectors,
// handshake, backpressure, flush and reset priority.
module tb_riscv_decode_stage;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, out_pc, imm;
    logic [4:0]  alu_op, rs1, rs2, rd;
    logic [1:0]  a_sel;
    logic        b_sel, reg_we, mem_req, mem_we, branch, jal, jalr, illegal;
    logic [2:0]  mem_size;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    riscv_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(instr), .in_pc_i(pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .alu_op_o(alu_op),
        .a_sel_o(a_sel), .b_sel_o(b_sel), .imm_o(imm),
        .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .reg_we_o(reg_we), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_size_o(mem_size), .branch_o(branch),
        .jal_o(jal), .jalr_o(jalr), .illegal_o(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        instr = 32'h002081B3; pc = 32'h100;
        tick(); tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_we", {31'b0, reg_we}, 32'd0);
        chk("rst_alu", {27'b0, alu_op}, 32'd0);
        chk("rst_imm", imm, 32'd0);

        rstn = 1'b1;
        tick();
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_alu", {27'b0, alu_op}, 32'd0);
        chk("add_rs1", {27'b0, rs1}, 32'd1);
        chk("add_rs2", {27'b0, rs2}, 32'd2);
        chk("add_rd", {27'b0, rd}, 32'd3);
        chk("add_we", {31'b0, reg_we}, 32'd1);
        chk("add_bsel", {31'b0, b_sel}, 32'd0);
        chk("add_pc", out_pc, 32'h100);

        instr = 32'h407302B3; pc = 32'h104;
        tick();
        chk("sub_valid", {31'b0, out_valid}, 32'd1);
        chk("sub_alu", {27'b0, alu_op}, 32'd8);
        chk("sub_rd", {27'b0, rd}, 32'd5);
        chk("sub_pc", out_pc, 32'h104);

        instr = 32'hFFF00093; pc = 32'h108;
        tick();
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_bsel", {31'b0, b_sel}, 32'd1);
        chk("addi_alu", {27'b0, alu_op}, 32'd0);

        instr = 32'h40315093;
        tick();
        chk("srai_alu", {27'b0, alu_op}, 32'd13);
        chk("srai_sh", {27'b0, imm[4:0]}, 32'd3);
        chk("srai_ill", {31'b0, illegal}, 32'd0);

        instr = 32'h00208463;
        tick();
        chk("beq_br", {31'b0, branch}, 32'd1);
        chk("beq_alu", {27'b0, alu_op}, 32'd24);
        chk("beq_imm", imm, 32'h8);
        chk("beq_we", {31'b0, reg_we}, 32'd0);

        instr = 32'h0000A103;
        tick();
        chk("lw_req", {31'b0, mem_req}, 32'd1);
        chk("lw_size", {29'b0, mem_size}, 32'd2);
        chk("lw_we", {31'b0, reg_we}, 32'd1);

        instr = 32'h0020A223;
        tick();
        chk("sw_mwe", {31'b0, mem_we}, 32'd1);
        chk("sw_imm", imm, 32'h4);
        chk("sw_we", {31'b0, reg_we}, 32'd0);

        instr = 32'h123450B7;
        tick();
        chk("lui_imm", imm, 32'h1234_5000);
        chk("lui_asel", {30'b0, a_sel}, 32'd2);

        instr = 32'h00000000;
        tick();
        chk("zero_valid", {31'b0, out_valid}, 32'd1);
        chk("zero_ill", {31'b0, illegal}, 32'd1);
        chk("zero_we", {31'b0, reg_we}, 32'd0);
        chk("zero_req", {31'b0, mem_req}, 32'd0);

        instr = 32'h40001033;
        tick();
        chk("badf7_ill", {31'b0, illegal}, 32'd1);
        chk("badf7_we", {31'b0, reg_we}, 32'd0);

        instr = 32'hFFF00093; pc = 32'h200;
        tick();
        chk("bp_load", {31'b0, out_valid}, 32'd1);

        out_ready = 1'b0; instr = 32'h002081B3; pc = 32'h204;
        #1;
        chk("bp_ready0", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_imm", imm, 32'hFFFF_FFFF);
            chk("bp_pc", out_pc, 32'h200);
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
        end

        flush = 1'b1;
        #1;
        chk("fl_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("fl_valid", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b1;
        tick();
        chk("fl_drop", {31'b0, out_valid}, 32'd0);

        flush = 1'b0;
        tick();
        chk("post_fl", {31'b0, out_valid}, 32'd1);
        chk("post_pc", out_pc, 32'h204);

        rstn = 1'b0; flush = 1'b1;
        tick();
        chk("rf_valid", {31'b0, out_valid}, 32'd0);
        chk("rf_pc", out_pc, 32'h0);
        chk("rf_we", {31'b0, reg_we}, 32'd0);
        chk("rf_rd", {27'b0, rd}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
